// File: rtl/parity4_rx_v.sv
// Serial nibble receiver: start bit, 4 data bits (MSB first), parity bit, stop bit.
// Samples i_sd only on strobed edges, reports each frame with a one-cycle o_valid
// pulse and keeps a saturating count of frames that carried a parity or framing error.
module parity4_rx_v #(
  parameter int unsigned EVEN_PAR = 1,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_bit_en,
  input  logic             i_sd,
  input  logic             i_clr,
  output logic [3:0]       o_data,
  output logic             o_valid,
  output logic             o_par_err,
  output logic             o_frm_err,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_err_cnt
);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  // XOR of data and parity bits that a correct frame must produce
  localparam logic PAR_REF = (EVEN_PAR != 0) ? 1'b0 : 1'b1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [1:0]       bit_idx_q, bit_idx_d;
  logic [3:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic [3:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             par_err_q, par_err_d;
  logic             frm_err_q, frm_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             par_bad;
  logic             frame_done;

  // Next-state: frame FSM, result capture and saturating error counter
  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    par_d      = par_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    par_err_d  = par_err_q;
    frm_err_d  = frm_err_q;
    cnt_d      = cnt_q;
    frame_done = 1'b0;
    par_bad    = ((^shift_q) ^ par_q) != PAR_REF;

    if (i_bit_en) begin
      unique case (state_q)
        StIdle: begin
          if (!i_sd) begin
            state_d   = StData;
            bit_idx_d = 2'd0;
          end
        end
        StData: begin
          shift_d   = {shift_q[2:0], i_sd};
          bit_idx_d = bit_idx_q + 2'd1;
          if (bit_idx_q == 2'd3) begin
            state_d = StParity;
          end
        end
        StParity: begin
          par_d   = i_sd;
          state_d = StStop;
        end
        StStop: begin
          // A 0 stop bit still returns to idle; it is never reused as a start bit
          frame_done = 1'b1;
          state_d    = StIdle;
          data_d     = shift_q;
          par_err_d  = par_bad;
          frm_err_d  = !i_sd;
          valid_d    = 1'b1;
        end
        default: state_d = StIdle;
      endcase
    end

    if (i_clr) begin
      cnt_d = '0;
    end else if (frame_done && (par_bad || !i_sd) && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      bit_idx_q <= 2'd0;
      shift_q   <= 4'd0;
      par_q     <= 1'b0;
      data_q    <= 4'd0;
      valid_q   <= 1'b0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_data    = data_q;
  assign o_valid   = valid_q;
  assign o_par_err = par_err_q;
  assign o_frm_err = frm_err_q;
  assign o_busy    = (state_q != StIdle);
  assign o_err_cnt = cnt_q;

endmodule

// File: tb/tb_parity4_rx_v.sv
// Bench for parity4_rx_v: three instances (even/8-bit, odd/8-bit, even/2-bit counter)
// share one stimulus stream; directed frames plus a randomized frame run against a model.
module tb_parity4_rx_v;

  logic       clk = 1'b0;
  logic       rst_n, bit_en, sd, clr;
  logic [3:0] e_data, o_data, c_data;
  logic       e_valid, o_valid, c_valid;
  logic       e_par, o_par, c_par;
  logic       e_frm, o_frm, c_frm;
  logic       e_busy, o_busy, c_busy;
  logic [7:0] e_cnt, o_cnt;
  logic [1:0] c_cnt;
  logic [41:0] all_out;

  int errors = 0;
  int checks = 0;

  // observations captured by send_frame
  int         ob_vcnt, ob_busy_bad;
  logic       s_valid, s_valid_next, s_busy;
  logic [11:0] s_data;
  logic [2:0] s_par, s_frm;
  logic [17:0] s_cnt;

  // reference model state
  int m_ce, m_co, m_cc;

  always #5 clk = ~clk;

  assign all_out = {e_data, o_data, c_data, e_valid, o_valid, c_valid, e_par, o_par, c_par,
                    e_frm, o_frm, c_frm, e_busy, o_busy, c_busy, e_cnt, o_cnt, c_cnt};

  parity4_rx_v #(.EVEN_PAR(1), .CNT_W(8)) dut_even (
    .i_clk(clk), .i_rst_n(rst_n), .i_bit_en(bit_en), .i_sd(sd), .i_clr(clr),
    .o_data(e_data), .o_valid(e_valid), .o_par_err(e_par), .o_frm_err(e_frm),
    .o_busy(e_busy), .o_err_cnt(e_cnt)
  );

  parity4_rx_v #(.EVEN_PAR(0), .CNT_W(8)) dut_odd (
    .i_clk(clk), .i_rst_n(rst_n), .i_bit_en(bit_en), .i_sd(sd), .i_clr(clr),
    .o_data(o_data), .o_valid(o_valid), .o_par_err(o_par), .o_frm_err(o_frm),
    .o_busy(o_busy), .o_err_cnt(o_cnt)
  );

  parity4_rx_v #(.EVEN_PAR(1), .CNT_W(2)) dut_c2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_bit_en(bit_en), .i_sd(sd), .i_clr(clr),
    .o_data(c_data), .o_valid(c_valid), .o_par_err(c_par), .o_frm_err(c_frm),
    .o_busy(c_busy), .o_err_cnt(c_cnt)
  );

  // Drive one frame (f[6] first), with gap idle cycles after each non-final bit.
  task automatic send_frame(input logic [6:0] f, input int gap, input bit clr_last);
    ob_vcnt     = 0;
    ob_busy_bad = 0;
    for (int i = 6; i >= 0; i--) begin
      @(negedge clk);
      bit_en = 1'b1;
      sd     = f[i];
      clr    = clr_last && (i == 0);
      @(posedge clk);
      #1;
      ob_vcnt += int'(e_valid) + int'(o_valid) + int'(c_valid);
      if (i > 0) begin
        if (!(e_busy && o_busy && c_busy)) ob_busy_bad++;
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          bit_en = 1'b0;
          sd     = 1'($urandom);
          clr    = 1'b0;
          @(posedge clk);
          #1;
          ob_vcnt += int'(e_valid) + int'(o_valid) + int'(c_valid);
          if (!(e_busy && o_busy && c_busy)) ob_busy_bad++;
        end
      end else begin
        s_valid = e_valid & o_valid & c_valid;
        s_data  = {e_data, o_data, c_data};
        s_par   = {e_par, o_par, c_par};
        s_frm   = {e_frm, o_frm, c_frm};
        s_cnt   = {e_cnt, o_cnt, c_cnt};
        s_busy  = e_busy | o_busy | c_busy;
      end
    end
    @(negedge clk);
    bit_en = 1'b0;
    sd     = 1'b1;
    clr    = 1'b0;
    @(posedge clk);
    #1;
    ob_vcnt += int'(e_valid) + int'(o_valid) + int'(c_valid);
    s_valid_next = e_valid | o_valid | c_valid;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL reset_state: got %h want 0", all_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL reset_release: got %h want 0", all_out);
    end
  endtask

  task automatic test_good();
    send_frame(7'b0101111, 0, 1'b0);
    checks++;
    if (s_data !== {3{4'b1011}}) begin
      errors++;
      $display("FAIL good_data: got %h want %h", s_data, {3{4'b1011}});
    end
    checks++;
    if (ob_vcnt != 3 || s_valid !== 1'b1 || s_valid_next !== 1'b0) begin
      errors++;
      $display("FAIL good_valid: pulses %0d at_stop %b next %b want 3 1 0",
               ob_vcnt, s_valid, s_valid_next);
    end
    checks++;
    if ({s_par, s_frm} !== 6'b010_000) begin
      errors++;
      $display("FAIL good_flags: got %b want 010000", {s_par, s_frm});
    end
    checks++;
    if (s_cnt !== {8'd0, 8'd1, 2'd0}) begin
      errors++;
      $display("FAIL good_cnt: got %h want %h", s_cnt, {8'd0, 8'd1, 2'd0});
    end
    checks++;
    if (ob_busy_bad != 0 || s_busy !== 1'b0) begin
      errors++;
      $display("FAIL good_busy: mid_bad %0d end %b want 0 0", ob_busy_bad, s_busy);
    end
  endtask

  task automatic test_par_err();
    send_frame(7'b0101101, 0, 1'b0);
    checks++;
    if (s_data !== {3{4'b1011}} || s_valid !== 1'b1) begin
      errors++;
      $display("FAIL par_data: got %h/%b want %h/1", s_data, s_valid, {3{4'b1011}});
    end
    checks++;
    if ({s_par, s_frm} !== 6'b101_000) begin
      errors++;
      $display("FAIL par_flags: got %b want 101000", {s_par, s_frm});
    end
    checks++;
    if (s_cnt !== {8'd1, 8'd1, 2'd1}) begin
      errors++;
      $display("FAIL par_cnt: got %h want %h", s_cnt, {8'd1, 8'd1, 2'd1});
    end
  endtask

  task automatic test_frm_err();
    send_frame(7'b0000000, 0, 1'b0);
    checks++;
    if ({s_par, s_frm} !== 6'b010_111 || s_valid !== 1'b1) begin
      errors++;
      $display("FAIL frm_flags: got %b/%b want 010111/1", {s_par, s_frm}, s_valid);
    end
    checks++;
    if (s_busy !== 1'b0 || s_cnt !== {8'd2, 8'd2, 2'd2}) begin
      errors++;
      $display("FAIL frm_cnt_busy: got %h/%b want %h/0", s_cnt, s_busy, {8'd2, 8'd2, 2'd2});
    end
    // the very next 0 sample must be taken as a fresh start bit
    send_frame(7'b0110001, 0, 1'b0);
    checks++;
    if (s_data !== {3{4'b1100}} || {s_par, s_frm} !== 6'b010_000 || ob_vcnt != 3) begin
      errors++;
      $display("FAIL frm_next_frame: got %h %b pulses %0d want %h 010000 3",
               s_data, {s_par, s_frm}, ob_vcnt, {3{4'b1100}});
    end
    checks++;
    if (s_cnt !== {8'd2, 8'd3, 2'd2}) begin
      errors++;
      $display("FAIL frm_next_cnt: got %h want %h", s_cnt, {8'd2, 8'd3, 2'd2});
    end
  endtask

  task automatic test_gaps();
    send_frame(7'b0110001, 5, 1'b0);
    checks++;
    if (s_data !== {3{4'b1100}}) begin
      errors++;
      $display("FAIL gap_data: got %h want %h", s_data, {3{4'b1100}});
    end
    checks++;
    if (ob_vcnt != 3 || s_valid !== 1'b1 || s_valid_next !== 1'b0) begin
      errors++;
      $display("FAIL gap_valid: pulses %0d at_stop %b next %b want 3 1 0",
               ob_vcnt, s_valid, s_valid_next);
    end
    checks++;
    if ({s_par[2], s_par[0], s_frm} !== 5'b00_000 || s_cnt !== {8'd2, 8'd4, 2'd2}) begin
      errors++;
      $display("FAIL gap_errs: got %b %b %h want 111->010 000 %h",
               s_par, s_frm, s_cnt, {8'd2, 8'd4, 2'd2});
    end
    checks++;
    if (ob_busy_bad != 0) begin
      errors++;
      $display("FAIL gap_busy: got %0d idle-busy samples want 0", ob_busy_bad);
    end
  endtask

  task automatic test_mid_reset();
    logic [3:0] pre;
    int         vc;
    pre = 4'b0101;
    for (int i = 3; i >= 0; i--) begin
      @(negedge clk);
      bit_en = 1'b1;
      sd     = pre[i];
      @(posedge clk);
    end
    @(negedge clk);
    bit_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL midrst_async: got %h want 0", all_out);
    end
    vc = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      vc += int'(e_valid) + int'(o_valid) + int'(c_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    vc += int'(e_valid) + int'(o_valid) + int'(c_valid);
    checks++;
    if (vc != 0 || all_out !== '0) begin
      errors++;
      $display("FAIL midrst_quiet: pulses %0d outs %h want 0 0", vc, all_out);
    end
    send_frame(7'b0101111, 1, 1'b0);
    checks++;
    if (s_data !== {3{4'b1011}} || ob_vcnt != 3 || s_cnt !== {8'd0, 8'd1, 2'd0}) begin
      errors++;
      $display("FAIL midrst_next: got %h pulses %0d cnt %h want %h 3 %h",
               s_data, ob_vcnt, s_cnt, {3{4'b1011}}, {8'd0, 8'd1, 2'd0});
    end
  endtask

  task automatic test_sat_clr();
    for (int k = 1; k <= 5; k++) begin
      send_frame(7'b0101110, 0, 1'b0);
      checks++;
      if (s_cnt[1:0] !== 2'((k > 3) ? 3 : k) || s_frm !== 3'b111) begin
        errors++;
        $display("FAIL sat_step%0d: cnt2 %0d frm %b want %0d 111",
                 k, s_cnt[1:0], s_frm, (k > 3) ? 3 : k);
      end
    end
    checks++;
    if (s_cnt !== {8'd5, 8'd6, 2'd3}) begin
      errors++;
      $display("FAIL sat_final: got %h want %h", s_cnt, {8'd5, 8'd6, 2'd3});
    end
    send_frame(7'b0101110, 0, 1'b1);
    checks++;
    if (s_cnt !== '0) begin
      errors++;
      $display("FAIL clr_prio: got %h want 0", s_cnt);
    end
    checks++;
    if (s_valid !== 1'b1 || s_frm !== 3'b111 || s_data !== {3{4'b1011}} ||
        s_par !== 3'b010) begin
      errors++;
      $display("FAIL clr_others: valid %b frm %b data %h par %b want 1 111 %h 010",
               s_valid, s_frm, s_data, {3{4'b1011}}, s_par);
    end
    checks++;
    if ({e_cnt, o_cnt, c_cnt} !== '0) begin
      errors++;
      $display("FAIL clr_hold: got %h want 0", {e_cnt, o_cnt, c_cnt});
    end
  endtask

  task automatic test_random();
    logic [6:0] f;
    logic [3:0] d;
    int         ones, idle_bad, gap;
    bit         pe, po, fe, clr_now;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_ce = 0;
    m_co = 0;
    m_cc = 0;
    for (int n = 0; n < 40; n++) begin
      idle_bad = 0;
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        bit_en = 1'b1;
        sd     = 1'b1;
        clr    = 1'b0;
        @(posedge clk);
        #1;
        if (e_valid || o_valid || c_valid || e_busy || o_busy || c_busy) idle_bad++;
      end
      f       = {1'b0, 6'($urandom)};
      f[0]    = ($urandom_range(0, 3) != 0);
      gap     = $urandom_range(0, 2);
      clr_now = ($urandom_range(0, 7) == 0);
      send_frame(f, gap, clr_now);

      // reference: frame rules evaluated directly
      d    = f[5:2];
      ones = $countones(f[5:1]);
      pe   = (ones % 2) != 0;
      po   = (ones % 2) != 1;
      fe   = (f[0] == 1'b0);
      if (clr_now) begin
        m_ce = 0;
        m_co = 0;
        m_cc = 0;
      end else begin
        if (pe || fe) m_ce = (m_ce == 255) ? 255 : m_ce + 1;
        if (po || fe) m_co = (m_co == 255) ? 255 : m_co + 1;
        if (pe || fe) m_cc = (m_cc == 3) ? 3 : m_cc + 1;
      end

      checks++;
      if (idle_bad != 0) begin
        errors++;
        $display("FAIL rnd%0d_idle: got %0d active samples want 0", n, idle_bad);
      end
      checks++;
      if (s_data !== {3{d}}) begin
        errors++;
        $display("FAIL rnd%0d_data: got %h want %h", n, s_data, {3{d}});
      end
      checks++;
      if (s_par !== {pe, po, pe} || s_frm !== {3{fe}}) begin
        errors++;
        $display("FAIL rnd%0d_flags: got %b %b want %b %b", n, s_par, s_frm,
                 {pe, po, pe}, {3{fe}});
      end
      checks++;
      if (s_cnt !== {8'(m_ce), 8'(m_co), 2'(m_cc)}) begin
        errors++;
        $display("FAIL rnd%0d_cnt: got %h want %h", n, s_cnt, {8'(m_ce), 8'(m_co), 2'(m_cc)});
      end
      checks++;
      if (ob_vcnt != 3 || s_valid_next !== 1'b0 || ob_busy_bad != 0 || s_busy !== 1'b0) begin
        errors++;
        $display("FAIL rnd%0d_ctrl: pulses %0d next %b busy_bad %0d busy_end %b want 3 0 0 0",
                 n, ob_vcnt, s_valid_next, ob_busy_bad, s_busy);
      end
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    bit_en = 1'b0;
    sd     = 1'b1;
    clr    = 1'b0;
    test_reset();
    test_good();
    test_par_err();
    test_frm_err();
    test_gaps();
    test_mid_reset();
    test_sat_clr();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
